wr_burst_sequencer: RTL and testbench
=====================================

# wr_burst_sequencer

Upstream feeder for the write-clock consumer stage. It buffers a stream of data words in a small synchronous FIFO and emits fixed-length write bursts. Each burst carries a 2-bit state code; the consumer decodes `2'b11` as end-of-burst. The block runs in the single write clock domain that the consumer samples.

## Interface
- `DATA_W`, default 8: data word width.
- `DEPTH`, default 4: FIFO depth, a power of 2 with `DEPTH >= BURST_LEN`.
- `BURST_LEN`, default 4: beats per burst, range 1..`DEPTH`.
- `i_clk`  in  1  write clock. Single clock; all logic on posedge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_valid`  in  1  input word valid.
- `o_ready`  out  1  FIFO can accept a word.
- `i_data`  in  `DATA_W`  input word.
- `o_wr_en`  out  1  write beat valid. Registered.
- `o_wr_data`  out  `DATA_W`  write beat data. Registered.
- `o_wr_state`  out  2  FSM state code. Registered.
- `o_wr_last`  out  1  final beat of burst. Registered.
- `o_count`  out  `$clog2(DEPTH)+1`  FIFO occupancy.
- `o_overflow`  out  1  sticky drop flag.

## Operation
- Push: occurs when `i_valid && o_ready`. `o_ready = (count != DEPTH)`, decoded combinationally from the registered count.
- Overflow: `i_valid && !o_ready` drops the word and sets `o_overflow`. The flag clears only on reset.
- FSM states and encodings: IDLE=`2'b00`, ARM=`2'b01`, WRITE=`2'b10`, DONE=`2'b11`.
  - IDLE→ARM: when `count >= BURST_LEN`.
  - ARM→WRITE: unconditional. This edge also issues beat 0 (pop head, `o_wr_en<=1`, `o_wr_data<=head`).
  - WRITE: each edge issues the next beat. A beat counter tracks 0..`BURST_LEN-1`.
  - Edge issuing the final beat: state→DONE and `o_wr_last<=1`. The last beat is therefore visible with `o_wr_state==2'b11`.
  - `BURST_LEN==1`: ARM→DONE directly, issuing the single beat with `o_wr_last<=1`.
  - DONE→IDLE: unconditional. `o_wr_en`, `o_wr_last` ← 0.
- Simultaneous push and pop: allowed, and count is unchanged. When full, no push is possible; the pop frees a slot the next cycle.
- Pushes are accepted throughout a burst. The FIFO never underflows, because a burst starts only when `BURST_LEN` words are present.
- Reset: all registered outputs, FIFO pointers, count, beat counter, FSM (→IDLE) and `o_overflow` go to 0. `o_ready` reads 1.
- Reset mid-burst: the burst aborts with no DONE cycle, FIFO contents are discarded, and `o_wr_en` is 0 from the next cycle.

## Timing
- Burst start: the push that reaches `count==BURST_LEN` occurs at edge N. Then ARM at N+1, WRITE plus beat 0 at edge E=N+2.
- `o_wr_en` is high for exactly `BURST_LEN` consecutive cycles, E..E+`BURST_LEN`-1.
- `o_wr_last`: high in the final beat cycle only.
- Back-to-back bursts: at least 2 idle cycles between the last beat and the next beat 0 (DONE→IDLE, IDLE→ARM).
- `o_count` reflects pushes and pops one cycle after the edge.
- Latency from the first push to beat 0, with continuous input: `BURST_LEN+1` edges.

## Configuration
- Macro: `WR_BURST_PARITY_EN`.
- Defined: adds output port `o_wr_par` (1 bit), registered with `o_wr_data`. It equals `^o_wr_data` (even parity) and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `wr_burst_pkg`:
  - `typedef enum logic [1:0] wr_state_e` (IDLE, ARM, WRITE, DONE, with the fixed encodings above).
  - Localparams for the state codes used by the consumer decode.
- Sub-module `wr_burst_fifo`:
  - Synchronous FIFO with `DATA_W`/`DEPTH` params, push/pop, head data, count.
  - Same clock and synchronous active-low reset.
- Top level holds the FSM, beat counter, overflow flag and output registers.

## Test plan
- **Reset:** hold `i_rst_n=0` for 3 cycles with `i_valid=1` → all outputs 0, `o_ready=1`, `o_count=0`, no push.
- **Single burst:** push 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles → `o_wr_en` high 4 cycles starting 2 edges after the 4th push, with data 11,22,33,44 in order. The last beat has `o_wr_state=2'b11` and `o_wr_last=1`. Afterwards `o_count=0`.
- **Overflow:** push 5 words with no burst running (hold `i_valid` while full) → the 5th word is dropped, `o_overflow=1` and stays set, `o_ready=0` at count 4.
- **Streaming:** continuous `i_valid` for 12 words → 3 bursts with order preserved, a gap of at least 2 cycles between bursts, `o_overflow=0`.
- **Mid-burst reset:** assert reset during beat 2 → `o_wr_en=0` the next cycle, `o_count=0`, FSM IDLE, no DONE code emitted.
- **`BURST_LEN=1` with `WR_BURST_PARITY_EN`:** push 8'h07 → single beat with `o_wr_state=2'b11`, `o_wr_last=1`, `o_wr_par=1`.

Source files
------------

// File: rtl/wr_burst_pkg.sv
// ---------------------------------------------------------------------------
// wr_burst_pkg
// Shared definitions for the write-burst sequencer: the 2-bit state codes the
// downstream write-clock consumer decodes, and the FSM state type built on
// those same codes so the state register can drive o_wr_state directly.
// ---------------------------------------------------------------------------
package wr_burst_pkg;

  localparam logic [1:0] WR_CODE_IDLE  = 2'b00;
  localparam logic [1:0] WR_CODE_ARM   = 2'b01;
  localparam logic [1:0] WR_CODE_WRITE = 2'b10;
  localparam logic [1:0] WR_CODE_DONE  = 2'b11;  // consumer: end-of-burst

  typedef enum logic [1:0] {
    ST_IDLE  = WR_CODE_IDLE,
    ST_ARM   = WR_CODE_ARM,
    ST_WRITE = WR_CODE_WRITE,
    ST_DONE  = WR_CODE_DONE
  } wr_state_e;

endpackage

// File: rtl/wr_burst_fifo.sv
// ---------------------------------------------------------------------------
// wr_burst_fifo
// Small synchronous FIFO with a combinational head-of-queue read.
// The caller gates push with (count != DEPTH) and only pops when non-empty,
// so no internal full/empty protection is applied.
// Ports:
//   i_clk    - clock, all logic on posedge
//   i_rst_n  - synchronous active-low reset (pointers and count only)
//   i_push   - write i_data at the tail
//   i_pop    - drop the head entry
//   i_data   - word to push
//   o_head   - current head entry
//   o_count  - occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wr_burst_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  // Storage carries no reset; stale entries are never read because the
  // pointers and count are cleared.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/wr_burst_sequencer.sv
// ---------------------------------------------------------------------------
// wr_burst_sequencer
// Buffers an input word stream and emits fixed-length write bursts toward the
// write-clock consumer. A burst starts only once BURST_LEN words are queued,
// so the FIFO can never underflow mid-burst. The final beat is presented with
// state code DONE (2'b11) together with o_wr_last.
// Optional feature macro: WR_BURST_PARITY_EN adds o_wr_par (even parity of
// o_wr_data, registered alongside it).
// Ports:
//   i_clk       - write clock
//   i_rst_n     - synchronous active-low reset
//   i_valid     - input word valid
//   o_ready     - FIFO not full
//   i_data      - input word
//   o_wr_en     - write beat valid (registered)
//   o_wr_data   - write beat data (registered)
//   o_wr_state  - FSM state code (registered)
//   o_wr_last   - final beat of burst (registered)
//   o_count     - FIFO occupancy
//   o_wr_par    - even parity of o_wr_data (WR_BURST_PARITY_EN only)
//   o_overflow  - sticky: a word arrived while full and was dropped
// ---------------------------------------------------------------------------
module wr_burst_sequencer
  import wr_burst_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_wr_en,
  output logic [DATA_W-1:0]        o_wr_data,
  output logic [1:0]               o_wr_state,
  output logic                     o_wr_last,
  output logic [$clog2(DEPTH):0]   o_count,
`ifdef WR_BURST_PARITY_EN
  output logic                     o_wr_par,
`endif
  output logic                     o_overflow
);

  localparam int                CNT_W  = $clog2(DEPTH) + 1;
  localparam int                BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  BL_C    = CNT_W'(BURST_LEN);
  localparam logic [BCNT_W-1:0] BL_M1   = BCNT_W'(BURST_LEN - 1);

  wr_state_e         r_state, w_state_nxt;
  logic [BCNT_W-1:0] r_beat, w_beat_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_wr_last, w_wr_last_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;

  assign o_ready = (w_count != DEPTH_C);
  assign w_push  = i_valid && o_ready;

  wr_burst_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Next-state and next-output decode. Every beat-issuing edge pops the head
  // and loads it into the output register in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_wr_en_nxt   = r_wr_en;
    w_wr_last_nxt = r_wr_last;
    w_wr_data_nxt = r_wr_data;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_count >= BL_C) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        w_pop         = 1'b1;
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = w_head;
        if (BURST_LEN == 1) begin
          w_state_nxt   = ST_DONE;
          w_wr_last_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WRITE;
          w_beat_nxt  = BCNT_W'(1);
        end
      end
      ST_WRITE: begin
        w_pop         = 1'b1;
        w_wr_en_nxt   = 1'b1;
        w_wr_data_nxt = w_head;
        if (r_beat == BL_M1) begin
          // Last beat is shown while the state code reads DONE.
          w_state_nxt   = ST_DONE;
          w_wr_last_nxt = 1'b1;
        end else begin
          w_beat_nxt = r_beat + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt   = ST_IDLE;
        w_beat_nxt    = '0;
        w_wr_en_nxt   = 1'b0;
        w_wr_last_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_last  <= 1'b0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_last <= w_wr_last_nxt;
      r_wr_data <= w_wr_data_nxt;
      if (i_valid && !o_ready) r_overflow <= 1'b1;
    end
  end

`ifdef WR_BURST_PARITY_EN
  logic r_wr_par;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_wr_par <= 1'b0;
    else          r_wr_par <= ^w_wr_data_nxt;
  end

  assign o_wr_par = r_wr_par;
`endif

  assign o_wr_en    = r_wr_en;
  assign o_wr_data  = r_wr_data;
  assign o_wr_state = r_state;
  assign o_wr_last  = r_wr_last;
  assign o_count    = w_count;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_wr_burst_sequencer.sv
module tb_wr_burst_sequencer;

  localparam int DEPTH = 4;
  localparam int BL    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Main DUT: BURST_LEN = 4
  logic       v1 = 1'b0;
  logic [7:0] d1 = '0;
  logic       rdy1, en1, last1, ovf1;
  logic [7:0] wd1;
  logic [1:0] st1;
  logic [2:0] cnt1;

  // Second DUT: BURST_LEN = 1 boundary
  logic       v2 = 1'b0;
  logic [7:0] d2 = '0;
  logic       rdy2, en2, last2, ovf2;
  logic [7:0] wd2;
  logic [1:0] st2;
  logic [2:0] cnt2;
`ifdef WR_BURST_PARITY_EN
  logic       par1, par2;
`endif

  int checks = 0;
  int errors = 0;
  int nlast  = 0;

  always #5 clk = ~clk;

  wr_burst_sequencer #(.DATA_W(8), .DEPTH(DEPTH), .BURST_LEN(BL)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(rdy1), .i_data(d1),
    .o_wr_en(en1), .o_wr_data(wd1), .o_wr_state(st1), .o_wr_last(last1),
    .o_count(cnt1),
`ifdef WR_BURST_PARITY_EN
    .o_wr_par(par1),
`endif
    .o_overflow(ovf1)
  );

  wr_burst_sequencer #(.DATA_W(8), .DEPTH(DEPTH), .BURST_LEN(1)) u_dut_bl1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2), .i_data(d2),
    .o_wr_en(en2), .o_wr_data(wd2), .o_wr_state(st2), .o_wr_last(last2),
    .o_count(cnt2),
`ifdef WR_BURST_PARITY_EN
    .o_wr_par(par2),
`endif
    .o_overflow(ovf2)
  );

  // Reference model for the main DUT: queue of accepted words plus a burst
  // timeline counter m_tl = edges since the burst was triggered
  // (1 = arm cycle, 2..BL+1 = beat cycles, 0 = idle).
  logic [7:0] m_q[$];
  int         m_tl   = 0;
  logic       m_ovf  = 1'b0;
  logic [7:0] m_data = '0;

  task automatic model_edge(input logic v, input logic [7:0] d, input logic rn);
    bit acc, trig;
    if (!rn) begin
      m_q.delete();
      m_tl   = 0;
      m_ovf  = 1'b0;
      m_data = '0;
      return;
    end
    acc  = v && (m_q.size() != DEPTH);
    trig = (m_tl == 0) && (m_q.size() >= BL);
    if (v && !acc) m_ovf = 1'b1;
    if (m_tl >= 1 && m_tl <= BL) m_data = m_q.pop_front();
    if (acc) m_q.push_back(d);
    if (trig)               m_tl = 1;
    else if (m_tl == BL + 1) m_tl = 0;
    else if (m_tl != 0)      m_tl = m_tl + 1;
  endtask

  function automatic logic [1:0] m_state();
    if (m_tl == 0)      return 2'b00;
    if (m_tl == 1)      return 2'b01;
    if (m_tl == BL + 1) return 2'b11;
    return 2'b10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_main();
    check("count",    32'(cnt1),  32'(m_q.size()));
    check("ready",    32'(rdy1),  32'(m_q.size() != DEPTH));
    check("overflow", 32'(ovf1),  32'(m_ovf));
    check("wr_en",    32'(en1),   32'(m_tl >= 2));
    check("wr_last",  32'(last1), 32'(m_tl == BL + 1));
    check("wr_state", 32'(st1),   32'(m_state()));
    check("wr_data",  32'(wd1),   32'(m_data));
`ifdef WR_BURST_PARITY_EN
    check("wr_par",   32'(par1),  32'(^m_data));
`endif
    if (last1) nlast++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic rn);
    v1 = v; d1 = d; rst_n = rn;
    @(posedge clk);
    model_edge(v, d, rn);
    #1;
    check_main();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [12];
    logic [7:0] single [4];
    int k, n;
    logic v;

    // Reset held 3 cycles with valid high: nothing is pushed.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 1'b0);
    check("rst_count", 32'(cnt1), 32'd0);
    check("rst_ready", 32'(rdy1), 32'd1);

    // Single burst 11,22,33,44.
    single[0] = 8'h11; single[1] = 8'h22; single[2] = 8'h33; single[3] = 8'h44;
    for (int i = 0; i < 4; i++) step(1'b1, single[i], 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check("single_beat0_data", 32'(wd1), 32'h11);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    check("single_count_after", 32'(cnt1), 32'd0);

    // Streaming 12 words, valid offered whenever a slot is free.
    for (int i = 0; i < 12; i++) words[i] = 8'(8'h30 + i);
    nlast = 0;
    k = 0;
    n = 0;
    while ((k < 12 || m_q.size() != 0 || m_tl != 0) && n < 200) begin
      v = (k < 12) && (m_q.size() != DEPTH);
      step(v, (k < 12) ? words[k] : 8'h00, 1'b1);
      if (v) k++;
      n++;
    end
    check("stream_done_in_budget", 32'(n < 200), 32'd1);
    check("stream_bursts", 32'(nlast), 32'd3);
    check("stream_overflow", 32'(ovf1), 32'd0);

    // Overflow: five words with valid held, fifth is dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    check("ovf_ready_full", 32'(rdy1), 32'd0);
    step(1'b1, 8'h99, 1'b1);
    check("ovf_set", 32'(ovf1), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    check("ovf_sticky", 32'(ovf1), 32'd1);

    // Reset in the middle of a burst (during beat 2).
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b1);
    n = 0;
    while (m_tl != 4 && n < 20) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("midrst_reached_beat2", 32'(m_tl), 32'd4);
    check("midrst_beat2_data", 32'(wd1), 32'h72);
    step(1'b0, 8'h00, 1'b0);
    check("midrst_wr_en", 32'(en1), 32'd0);
    check("midrst_state", 32'(st1), 32'd0);
    check("midrst_count", 32'(cnt1), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("midrst_no_done", 32'(st1), 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 8'($urandom),
           ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
    end

    // BURST_LEN = 1 instance: single beat straight to DONE.
    step(1'b0, 8'h00, 1'b0);
    check("bl1_rst_state", 32'(st2), 32'd0);
    check("bl1_rst_ready", 32'(rdy2), 32'd1);
    v2 = 1'b1; d2 = 8'h07;
    step(1'b0, 8'h00, 1'b1);
    v2 = 1'b0; d2 = 8'h00;
    check("bl1_count_push", 32'(cnt2), 32'd1);
    check("bl1_idle", 32'(st2), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("bl1_arm", 32'(st2), 32'd1);
    check("bl1_arm_en", 32'(en2), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("bl1_beat_en", 32'(en2), 32'd1);
    check("bl1_beat_state", 32'(st2), 32'd3);
    check("bl1_beat_last", 32'(last2), 32'd1);
    check("bl1_beat_data", 32'(wd2), 32'h07);
    check("bl1_count_pop", 32'(cnt2), 32'd0);
`ifdef WR_BURST_PARITY_EN
    check("bl1_beat_par", 32'(par2), 32'd1);
`endif
    step(1'b0, 8'h00, 1'b1);
    check("bl1_after_en", 32'(en2), 32'd0);
    check("bl1_after_last", 32'(last2), 32'd0);
    check("bl1_after_state", 32'(st2), 32'd0);
    check("bl1_overflow", 32'(ovf2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
